// File: rtl/membus_arbiter_pkg.sv
// rtl/membus_arbiter_pkg.sv - shared widths and enums for the core memory bus arbiter
package membus_arbiter_pkg;

  localparam int XLEN = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;

  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} BusOwner;
  typedef enum logic {REQ_I, REQ_D} Requester;

endpackage

// File: rtl/membus_grant_sel.sv
// rtl/membus_grant_sel.sv - combinational fixed-priority / round-robin grant selector
module membus_grant_sel
  import membus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic     i_valid,
  input  logic     d_valid,
  input  Requester last_grant,
  input  logic     lock,
  input  Requester locked_sel,
  output Requester grant
);

  always_comb begin
    grant = REQ_I;
    if (lock) begin
      grant = locked_sel;
    end else if (i_valid && d_valid) begin
      // On conflict, round-robin hands the bus to whoever did not win last time
      if (ROUND_ROBIN) begin
        grant = (last_grant == REQ_I) ? REQ_D : REQ_I;
      end else begin
        grant = REQ_D;
      end
    end else if (d_valid) begin
      grant = REQ_D;
    end else begin
      grant = REQ_I;
    end
  end

endmodule

// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - two-to-one fetch/load-store arbiter for the single core memory bus
module membus_arbiter
  import membus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int ADDR_W      = XLEN,
  parameter int DATA_W      = MEMBUS_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                i_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_wen,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                protocol_err
);

  BusOwner  owner_q, owner_d;
  Requester last_grant_q, last_grant_d;
  Requester locked_sel_q, locked_sel_d;
  logic     lock_q, lock_d;
  logic     protocol_err_q, protocol_err_d;

  Requester grant;
  logic     can_issue;
  logic     grant_valid;
  logic     accept;

  membus_grant_sel #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_grant_sel (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .last_grant (last_grant_q),
    .lock       (lock_q),
    .locked_sel (locked_sel_q),
    .grant      (grant)
  );

  // A response arriving this cycle frees the slot, so a new request can issue without a bubble
  assign can_issue   = (owner_q == IDLE) || mem_rvalid;
  assign grant_valid = (grant == REQ_D) ? d_valid : i_valid;
  assign mem_valid   = can_issue && grant_valid;
  assign accept      = mem_valid && mem_ready;

  assign i_ready = accept && (grant == REQ_I);
  assign d_ready = accept && (grant == REQ_D);

  assign i_rvalid     = mem_rvalid && (owner_q == WAIT_I);
  assign d_rvalid     = mem_rvalid && (owner_q == WAIT_D);
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign protocol_err = protocol_err_q;

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (mem_valid) begin
      if (grant == REQ_D) begin
        mem_addr  = d_addr;
        mem_wen   = d_wen;
        mem_wdata = d_wdata;
        mem_wmask = d_wmask;
      end else begin
        mem_addr  = i_addr;
      end
    end
  end

  always_comb begin
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    locked_sel_d   = locked_sel_q;
    lock_d         = lock_q;
    protocol_err_d = protocol_err_q || (mem_rvalid && (owner_q == IDLE));
    if (accept) begin
      owner_d      = (grant == REQ_D) ? WAIT_D : WAIT_I;
      last_grant_d = grant;
      lock_d       = 1'b0;
    end else begin
      if (mem_rvalid) begin
        owner_d = IDLE;
      end
      // A stalled request keeps the bus until it is accepted
      if (mem_valid) begin
        lock_d       = 1'b1;
        locked_sel_d = grant;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q        <= IDLE;
      last_grant_q   <= REQ_I;
      locked_sel_q   <= REQ_I;
      lock_q         <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      owner_q        <= owner_d;
      last_grant_q   <= last_grant_d;
      locked_sel_q   <= locked_sel_d;
      lock_q         <= lock_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - directed bench with a transaction-level model for membus_arbiter
module tb_membus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 1'b0, d_valid = 1'b0, d_wen = 1'b0;
  logic [63:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [7:0]  d_wmask = '0;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;

  logic        i_ready, i_rvalid, d_ready, d_rvalid, mem_valid, mem_wen, protocol_err;
  logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;

  logic        f_i_ready, f_i_rvalid, f_d_ready, f_d_rvalid, f_mem_valid, f_mem_wen, f_protocol_err;
  logic [63:0] f_i_rdata, f_d_rdata, f_mem_addr, f_mem_wdata;
  logic [7:0]  f_mem_wmask;

  int vectors = 0;
  int errs = 0;

  // Model of the round-robin instance: who is outstanding (0 none, 1 fetch, 2 data),
  // who won last (0 fetch, 1 data), who is stuck on a stalled bus (-1 none)
  int   m_out  = 0;
  int   m_last = 0;
  int   m_held = -1;
  logic m_perr = 1'b0;

  always #5 clk = ~clk;

  membus_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .protocol_err(protocol_err)
  );

  membus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fixed (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(f_i_ready), .i_addr(i_addr), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
    .d_valid(d_valid), .d_ready(f_d_ready), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
    .mem_valid(f_mem_valid), .mem_ready(mem_ready), .mem_addr(f_mem_addr), .mem_wen(f_mem_wen),
    .mem_wdata(f_mem_wdata), .mem_wmask(f_mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .protocol_err(f_protocol_err)
  );

  task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which requester deserves the bus this cycle, ignoring whether the bus is free
  function automatic int pick();
    if (m_held >= 0) return m_held;
    if (i_valid && d_valid) return (m_last == 1) ? 0 : 1;
    if (i_valid) return 0;
    if (d_valid) return 1;
    return -1;
  endfunction

  function automatic logic bus_free();
    return (m_out == 0) || mem_rvalid;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out  <= 0;
      m_last <= 0;
      m_held <= -1;
      m_perr <= 1'b0;
    end else begin
      if (mem_rvalid && m_out == 0) m_perr <= 1'b1;
      if (bus_free() && pick() >= 0 && mem_ready) begin
        m_out  <= pick() + 1;
        m_last <= pick();
        m_held <= -1;
      end else begin
        if (mem_rvalid) m_out <= 0;
        if (bus_free() && pick() >= 0) m_held <= pick();
      end
    end
  end

  always @(negedge clk) begin : compare
    int   p;
    logic ev;
    if (!rst) begin
      p  = pick();
      ev = bus_free() && (p >= 0);
      lit("mem_valid", mem_valid, ev);
      lit("i_ready", i_ready, ev && p == 0 && mem_ready);
      lit("d_ready", d_ready, ev && p == 1 && mem_ready);
      lit("mem_addr", mem_addr, ev ? ((p == 1) ? d_addr : i_addr) : 64'h0);
      lit("mem_wen", mem_wen, (ev && p == 1) ? d_wen : 1'b0);
      lit("mem_wdata", mem_wdata, (ev && p == 1) ? d_wdata : 64'h0);
      lit("mem_wmask", mem_wmask, (ev && p == 1) ? d_wmask : 8'h0);
      lit("i_rvalid", i_rvalid, mem_rvalid && m_out == 1);
      lit("d_rvalid", d_rvalid, mem_rvalid && m_out == 2);
      lit("i_rdata", i_rdata, mem_rdata);
      lit("d_rdata", d_rdata, mem_rdata);
      lit("protocol_err", protocol_err, m_perr);
    end
  end

  task automatic drive(input logic iv, input logic [63:0] ia, input logic dv, input logic [63:0] da,
                       input logic we, input logic [63:0] wd, input logic [7:0] wm,
                       input logic mr, input logic rv, input logic [63:0] rd);
    i_valid = iv; i_addr = ia; d_valid = dv; d_addr = da;
    d_wen = we; d_wdata = wd; d_wmask = wm;
    mem_ready = mr; mem_rvalid = rv; mem_rdata = rd;
  endtask

  task automatic idle_in();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    @(negedge clk);
    lit("rst mem_valid", mem_valid, 0);
    lit("rst i_ready", i_ready, 0);
    lit("rst d_ready", d_ready, 0);
    lit("rst protocol_err", protocol_err, 0);
    tick();
    rst = 1'b0;

    // Single fetch with the response two cycles after accept
    drive(1, 64'h1000, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    lit("fetch i_ready", i_ready, 1);
    lit("fetch mem_addr", mem_addr, 64'h1000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    lit("fetch i_ready drop", i_ready, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'hDEAD);
    @(negedge clk);
    lit("fetch i_rvalid", i_rvalid, 1);
    lit("fetch i_rdata", i_rdata, 64'hDEAD);
    lit("fetch d_rvalid", d_rvalid, 0);
    tick();
    drive(0, 0, 1, 64'h2000, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    lit("idle again d_ready", d_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h55);
    @(negedge clk);
    lit("load d_rvalid", d_rvalid, 1);
    tick();
    idle_in();
    do_reset();

    // Sustained conflict with immediate responses
    drive(1, 64'h1000, 1, 64'h8000_0000, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    lit("conflict first d_ready", d_ready, 1);
    lit("conflict first i_ready", i_ready, 0);
    lit("conflict first mem_addr", mem_addr, 64'h8000_0000);
    lit("fixed first d_ready", f_d_ready, 1);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 64'h1000, 1, 64'h8000_0000, 0, 0, 0, 1, 1, 64'(k));
      @(negedge clk);
      lit("rr i_ready", i_ready, (k % 2) == 1);
      lit("rr d_ready", d_ready, (k % 2) == 0);
      lit("rr d_rvalid", d_rvalid, (k % 2) == 1);
      lit("fixed d_ready", f_d_ready, 1);
      lit("fixed i_ready", f_i_ready, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h9);
    tick();
    idle_in();
    do_reset();

    // Stall lock: fetch stalls three cycles while data request shows up
    for (int s = 0; s < 4; s++) begin
      drive(1, 64'h1000, s >= 1, 64'h8000_0000, 0, 0, 0, s == 3, 0, 0);
      @(negedge clk);
      lit("lock mem_addr", mem_addr, 64'h1000);
      lit("lock i_ready", i_ready, s == 3);
      lit("lock d_ready", d_ready, 0);
      lit("lock fixed mem_addr", f_mem_addr, 64'h1000);
      lit("lock fixed d_ready", f_d_ready, 0);
      tick();
    end

    // Fetch response coincides with a data store being accepted
    drive(0, 0, 1, 64'h8000_0000, 1, 64'h1122334455667788, 8'hFF, 1, 1, 64'hCAFE);
    @(negedge clk);
    lit("b2b i_rvalid", i_rvalid, 1);
    lit("b2b d_ready", d_ready, 1);
    lit("b2b mem_wdata", mem_wdata, 64'h1122334455667788);
    lit("b2b mem_wmask", mem_wmask, 8'hFF);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'hBEEF);
    @(negedge clk);
    lit("b2b owner d_rvalid", d_rvalid, 1);
    lit("b2b owner i_rvalid", i_rvalid, 0);
    tick();

    // Spurious response while idle
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 64'h77);
    @(negedge clk);
    lit("spur i_rvalid", i_rvalid, 0);
    lit("spur d_rvalid", d_rvalid, 0);
    tick();
    idle_in();
    @(negedge clk);
    lit("spur protocol_err", protocol_err, 1);
    tick();
    @(negedge clk);
    lit("spur protocol_err sticky", protocol_err, 1);
    tick();

    // Reset in the middle of a data read
    drive(0, 0, 1, 64'h3000, 0, 0, 0, 1, 0, 0);
    tick();
    idle_in();
    #2;
    rst = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    lit("mid rst protocol_err", protocol_err, 0);
    lit("mid rst d_rvalid", d_rvalid, 0);
    lit("mid rst mem_valid", mem_valid, 0);
    mem_rvalid = 1'b0;
    #1;
    rst = 1'b0;
    tick();
    @(negedge clk);
    lit("after rst protocol_err", protocol_err, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
